lcd_nibble_sequencer: RTL and testbench
=======================================

# lcd_nibble_sequencer

Byte-to-nibble write sequencer for the Spartan-3E character LCD in 4-bit mode. Sits directly upstream of the LCD write-enable pulse generator. Accepts one byte plus RS per valid/ready handshake, then:
- drives the high and low nibbles onto the LCD data bus,
- requests one enable pulse per nibble,
- enforces the HD44780 inter-nibble and post-command execution delays before accepting the next byte.

## Interface
Parameters:
- NIBBLE_GAP_CYC, 50: idle cycles between high-nibble done and low-nibble load (1 µs at 50 MHz).
- BYTE_GAP_CYC, 2000: post-byte execution wait (40 µs).
- LONG_GAP_CYC, 82000: post-byte wait for Clear/Home commands (1.64 ms).
- EN_TIMEOUT_CYC, 64: maximum cycles to wait for iEnDone.

Ports:
- Clock  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous, active-high.
- iValid  in  1  upstream byte valid.
- iData  in  8  byte to write.
- iRS  in  1  register select (0 = command, 1 = data).
- oReady  out  1  sequencer can accept a byte.
- oLCD_D  out  4  LCD data bus (SF_D[11:8]).
- oLCD_RS  out  1  LCD RS.
- oLCD_RW  out  1  tied 0 (write only).
- oEnStart  out  1  request to enable-pulse generator.
- iEnDone  in  1  enable-pulse generator finished.
- oError  out  1  sticky; set on iEnDone timeout.

## Operation
- Transfer occurs on a cycle with iValid & oReady. On that cycle iData and iRS are latched. oReady is high only in IDLE.
- States and transitions:
  - IDLE → LOAD_HI on transfer.
  - LOAD_HI (1 cycle): oLCD_D = byte[7:4], oLCD_RS = latched RS, oEnStart = 0. Goes to PULSE_HI.
  - PULSE_HI: oEnStart = 1. Leaves on iEnDone = 1 or on timeout, to GAP_NIB.
  - GAP_NIB: oEnStart = 0, data held. Lasts NIBBLE_GAP_CYC cycles, then LOAD_LO.
  - LOAD_LO (1 cycle): oLCD_D = byte[3:0]. Goes to PULSE_LO.
  - PULSE_LO: same rules as PULSE_HI, to GAP_BYTE.
  - GAP_BYTE: lasts LONG_GAP_CYC if latched RS = 0 and byte ∈ {0x01, 0x02, 0x03}, else BYTE_GAP_CYC. Then IDLE.
- oLCD_D and oLCD_RS change only on entry to LOAD_HI or LOAD_LO. They are held through the pulse and the gaps, giving data/RS setup and hold around E.
- Timeout: in a PULSE state, if iEnDone has not been seen after EN_TIMEOUT_CYC cycles, oError is set and the sequence proceeds as if iEnDone had arrived. oError clears only on Reset.
- iEnDone sampled outside the PULSE states is ignored.
- Gap counter is 17 bits, loaded on state entry, expires at terminal count; covers LONG_GAP_CYC ≤ 131071. A gap parameter of 0 is treated as 1.

## Timing
- Reset (while high and the first cycle after): oReady = 0, oLCD_D = 0, oLCD_RS = 0, oLCD_RW = 0, oEnStart = 0, oError = 0, counters cleared, state IDLE.
- oReady = 1 from the cycle after Reset is released.
- Transfer at cycle t:
  - t+1: LOAD_HI.
  - t+2: oEnStart rises.
  - Cycle after iEnDone is sampled high: oEnStart = 0.
- With the enable generator returning iEnDone P cycles after oEnStart rises, each PULSE state lasts P cycles.
- Byte latency, transfer to oReady high again = 2·(1 + P) + NIBBLE_GAP_CYC + gap + 1.
- Reset mid-operation aborts immediately. oEnStart drops with Reset and no further nibble is issued.
- iValid held with oReady low has no effect. No back-to-back acceptance: the earliest next transfer is the first IDLE cycle.

## Structure
- Shared package lcd_pkg holds:
  - state encoding (IDLE, LOAD_HI, PULSE_HI, GAP_NIB, LOAD_LO, PULSE_LO, GAP_BYTE);
  - default cycle constants;
  - command codes CMD_CLEAR = 0x01, CMD_HOME = 0x02.
- Sub-module lcd_delay_counter: load value, count enable, expired flag. Instantiated once for the gaps. The timeout counter is a local 7-bit counter.

## Test plan
- Reset, then a data write: iData = 0x41, iRS = 1, P = 16. Expect:
  - oLCD_D = 0x4 then 0x1;
  - two oEnStart pulses;
  - RS = 1 throughout;
  - oReady high again after 2·17 + 50 + 2000 + 1 cycles.
- Clear command, iData = 0x01, iRS = 0: GAP_BYTE lasts 82000 cycles. Then a command 0x28 uses a 2000-cycle gap.
- iEnDone never asserted: oError = 1 after 64 cycles in PULSE_HI. The sequence completes both nibbles and oError stays 1.
- Reset asserted during GAP_NIB: next cycle oEnStart = 0, oLCD_D = 0, oReady = 0. After release, oReady = 1 and no low nibble is ever issued.
- iValid held high continuously with three bytes queued: exactly three transfers occur, each only in IDLE. Data/RS are stable from LOAD to the end of each PULSE.
- Spurious iEnDone in IDLE and in GAP states: no state change, no oError.

Source files
------------

// File: rtl/lcd_nibble_sequencer_pkg.sv
// lcd_pkg: shared definitions for the character-LCD nibble sequencer.
//   - lcd_state_e   : sequencer state encoding
//   - *_DEF         : default cycle counts at 50 MHz
//   - CMD_CLEAR/HOME: HD44780 commands that need the long execution wait
//   - helpers       : long-command test and gap-counter load value
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_HI,
    PULSE_HI,
    GAP_NIB,
    LOAD_LO,
    PULSE_LO,
    GAP_BYTE
  } lcd_state_e;

  localparam int unsigned NIBBLE_GAP_CYC_DEF = 50;     // 1 us
  localparam int unsigned BYTE_GAP_CYC_DEF   = 2000;   // 40 us
  localparam int unsigned LONG_GAP_CYC_DEF   = 82000;  // 1.64 ms
  localparam int unsigned EN_TIMEOUT_CYC_DEF = 64;

  localparam int GAP_CNT_W = 17;
  localparam int TO_CNT_W  = 7;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Clear (0x01) and Return Home (0x02, and 0x03 since bit 0 is don't-care)
  // are the only commands with the long execution time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && ((b == CMD_CLEAR) || (b[7:1] == CMD_HOME[7:1]));
  endfunction

  // The counter expires at zero, so an N-cycle gap loads N-1; zero acts as one.
  function automatic logic [GAP_CNT_W-1:0] gap_count_load(input int unsigned cyc);
    return (cyc == 0) ? '0 : GAP_CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/lcd_nibble_sequencer_delay_counter.sv
// lcd_delay_counter: loadable down-counter used for the inter-nibble and
// post-byte gaps.
//   Clock, Reset : clock, synchronous active-high reset
//   load_i       : load load_val_i this cycle (takes priority over counting)
//   load_val_i   : cycles-minus-one of the next gap
//   count_en_i   : decrement while non-zero
//   expired_o    : count has reached zero (terminal count)
module lcd_delay_counter
  import lcd_pkg::*;
(
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 load_i,
  input  logic [GAP_CNT_W-1:0] load_val_i,
  input  logic                 count_en_i,
  output logic                 expired_o
);

  logic [GAP_CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/lcd_nibble_sequencer.sv
// lcd_nibble_sequencer: splits each accepted byte into two 4-bit LCD writes,
// requests one enable pulse per nibble and enforces the HD44780 gaps.
//   Clock, Reset : clock, synchronous active-high reset
//   iValid/iData/iRS, oReady : byte + register-select handshake
//   oLCD_D, oLCD_RS, oLCD_RW : LCD bus (RW always 0)
//   oEnStart / iEnDone       : handshake with the enable-pulse generator
//   oError                   : sticky, set when iEnDone times out
module lcd_nibble_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned NIBBLE_GAP_CYC = NIBBLE_GAP_CYC_DEF,
  parameter int unsigned BYTE_GAP_CYC   = BYTE_GAP_CYC_DEF,
  parameter int unsigned LONG_GAP_CYC   = LONG_GAP_CYC_DEF,
  parameter int unsigned EN_TIMEOUT_CYC = EN_TIMEOUT_CYC_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iValid,
  input  logic [7:0] iData,
  input  logic       iRS,
  output logic       oReady,
  output logic [3:0] oLCD_D,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic       oEnStart,
  input  logic       iEnDone,
  output logic       oError
);

  localparam logic [GAP_CNT_W-1:0] NIB_LOAD  = gap_count_load(NIBBLE_GAP_CYC);
  localparam logic [GAP_CNT_W-1:0] BYTE_LOAD = gap_count_load(BYTE_GAP_CYC);
  localparam logic [GAP_CNT_W-1:0] LONG_LOAD = gap_count_load(LONG_GAP_CYC);
  // Value of the pulse-cycle counter in the last permitted pulse cycle.
  localparam logic [TO_CNT_W-1:0]  TO_LAST   =
    (EN_TIMEOUT_CYC == 0) ? '0 : TO_CNT_W'(EN_TIMEOUT_CYC - 1);

  lcd_state_e           state_q, state_d;
  logic [7:0]           byte_q, byte_d;
  logic                 rs_q, rs_d;
  logic [3:0]           lcd_d_q, lcd_d_d;
  logic                 err_q, err_d;
  logic [TO_CNT_W-1:0]  to_q, to_d;
  logic                 armed_q;
  logic                 gap_load;
  logic [GAP_CNT_W-1:0] gap_val;
  logic                 gap_count_en;
  logic                 gap_expired;
  logic                 xfer;
  logic                 pulse_done;

  lcd_delay_counter u_gap (
    .Clock      (Clock),
    .Reset      (Reset),
    .load_i     (gap_load),
    .load_val_i (gap_val),
    .count_en_i (gap_count_en),
    .expired_o  (gap_expired)
  );

  // armed_q keeps oReady low through reset and the first cycle after it.
  assign oReady       = (state_q == IDLE) && armed_q;
  assign xfer         = iValid && oReady;
  assign pulse_done   = iEnDone || (to_q == TO_LAST);
  assign gap_count_en = (state_q == GAP_NIB) || (state_q == GAP_BYTE);

  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    rs_d     = rs_q;
    lcd_d_d  = lcd_d_q;
    err_d    = err_q;
    to_d     = to_q;
    gap_load = 1'b0;
    gap_val  = NIB_LOAD;
    oEnStart = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          byte_d  = iData;
          rs_d    = iRS;
          lcd_d_d = iData[7:4];
          state_d = LOAD_HI;
        end
      end
      LOAD_HI: begin
        to_d    = '0;
        state_d = PULSE_HI;
      end
      PULSE_HI: begin
        oEnStart = 1'b1;
        if (pulse_done) begin
          if (!iEnDone) err_d = 1'b1;
          gap_load = 1'b1;
          gap_val  = NIB_LOAD;
          state_d  = GAP_NIB;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      GAP_NIB: begin
        if (gap_expired) begin
          lcd_d_d = byte_q[3:0];
          state_d = LOAD_LO;
        end
      end
      LOAD_LO: begin
        to_d    = '0;
        state_d = PULSE_LO;
      end
      PULSE_LO: begin
        oEnStart = 1'b1;
        if (pulse_done) begin
          if (!iEnDone) err_d = 1'b1;
          gap_load = 1'b1;
          gap_val  = is_long_cmd(rs_q, byte_q) ? LONG_LOAD : BYTE_LOAD;
          state_d  = GAP_BYTE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      GAP_BYTE: begin
        if (gap_expired) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      byte_q  <= '0;
      rs_q    <= 1'b0;
      lcd_d_q <= '0;
      err_q   <= 1'b0;
      to_q    <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      rs_q    <= rs_d;
      lcd_d_q <= lcd_d_d;
      err_q   <= err_d;
      to_q    <= to_d;
      armed_q <= 1'b1;
    end
  end

  assign oLCD_D  = lcd_d_q;
  assign oLCD_RS = rs_q;
  assign oLCD_RW = 1'b0;
  assign oError  = err_q;

endmodule

// File: tb/tb_lcd_nibble_sequencer.sv
// Testbench for lcd_nibble_sequencer: every cycle's outputs are traced, and
// each byte is checked against a cycle timeline computed from the protocol
// rules (LOAD, P-cycle pulse, nibble gap, LOAD, pulse, byte gap).
module tb_lcd_nibble_sequencer;

  localparam int NG   = 50;
  localparam int BG   = 2000;
  localparam int LG   = 82000;
  localparam int TO   = 64;
  localparam int TR_N = 100000;

  logic       Clock;
  logic       Reset;
  logic       iValid;
  logic [7:0] iData;
  logic       iRS;
  logic       oReady;
  logic [3:0] oLCD_D;
  logic       oLCD_RS;
  logic       oLCD_RW;
  logic       oEnStart;
  logic       iEnDone;
  logic       oError;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int xfer_cnt    = 0;

  logic [3:0] d_tr   [TR_N];
  logic       rs_tr  [TR_N];
  logic       en_tr  [TR_N];
  logic       rdy_tr [TR_N];
  logic       err_tr [TR_N];
  logic       rw_tr  [TR_N];

  int resp_p   = 4;
  bit resp_on  = 1'b1;
  bit spurious = 1'b0;

  lcd_nibble_sequencer #(
    .NIBBLE_GAP_CYC (NG),
    .BYTE_GAP_CYC   (BG),
    .LONG_GAP_CYC   (LG),
    .EN_TIMEOUT_CYC (TO)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .iValid   (iValid),
    .iData    (iData),
    .iRS      (iRS),
    .oReady   (oReady),
    .oLCD_D   (oLCD_D),
    .oLCD_RS  (oLCD_RS),
    .oLCD_RW  (oLCD_RW),
    .oEnStart (oEnStart),
    .iEnDone  (iEnDone),
    .oError   (oError)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial forever begin
    @(posedge Clock);
    cyc = cyc + 1;
  end

  // Output trace, sampled mid-cycle.
  initial forever begin
    @(negedge Clock);
    if (cyc < TR_N) begin
      d_tr[cyc]   = oLCD_D;
      rs_tr[cyc]  = oLCD_RS;
      en_tr[cyc]  = oEnStart;
      rdy_tr[cyc] = oReady;
      err_tr[cyc] = oError;
      rw_tr[cyc]  = oLCD_RW;
    end
    if (iValid && oReady) xfer_cnt = xfer_cnt + 1;
  end

  // Enable-pulse generator model: iEnDone in the P-th cycle of oEnStart.
  initial begin
    int cnt;
    cnt = 0;
    iEnDone = 1'b0;
    forever begin
      @(negedge Clock);
      cnt = oEnStart ? cnt + 1 : 0;
      iEnDone = (resp_on && oEnStart && (cnt == resp_p)) || spurious;
    end
  end

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #2;
    end
  endtask

  task automatic wait_cycle(input int c);
    while (cyc < c) tick(1);
  endtask

  function automatic int gap_of(input logic [7:0] b, input logic rs);
    return (!rs && (b >= 8'd1) && (b <= 8'd3)) ? LG : BG;
  endfunction

  // Offer a byte; returns the cycle in which the transfer was seen.
  task automatic send(input logic [7:0] b, input logic rs, input bit hold, output int t);
    iData  = b;
    iRS    = rs;
    iValid = 1'b1;
    t      = -1;
    for (int k = 0; (k < 3000) && (t < 0); k++) begin
      @(negedge Clock);
      if (oReady) t = cyc;
    end
    check("xfer_seen", (t >= 0), 1);
    @(posedge Clock);
    #2;
    if (!hold) iValid = 1'b0;
    $display("byte 0x%02h rs=%0d accepted in cycle %0d", b, rs, t);
  endtask

  // Check a whole byte's timeline against the expected schedule.
  task automatic verify_byte(input string tag, input int t, input logic [7:0] b,
                             input logic rs, input int L, input logic err_hi,
                             input logic err_lo);
    int g, r, lo_load, rises, first_rdy;
    int bad_en, bad_d, bad_rs, bad_rdy, bad_err, bad_rw;
    logic       exp_en;
    logic [3:0] exp_d;
    logic       exp_err;
    g = gap_of(b, rs);
    r = t + 2 * (1 + L) + NG + g + 1;
    lo_load = t + 2 + L + NG;
    wait_cycle(r + 2);
    rises = 0; first_rdy = -1;
    bad_en = 0; bad_d = 0; bad_rs = 0; bad_rdy = 0; bad_err = 0; bad_rw = 0;
    for (int i = t + 1; i <= r; i++) begin
      exp_en  = ((i >= t + 2) && (i <= t + 1 + L)) ||
                ((i >= lo_load + 1) && (i <= lo_load + L));
      exp_d   = (i < lo_load) ? b[7:4] : b[3:0];
      exp_err = (i < t + 2 + L) ? err_hi : err_lo;
      if (en_tr[i] !== exp_en) bad_en++;
      if (d_tr[i] !== exp_d) bad_d++;
      if (rs_tr[i] !== rs) bad_rs++;
      if (rdy_tr[i] !== (i == r)) bad_rdy++;
      if (err_tr[i] !== exp_err) bad_err++;
      if (rw_tr[i] !== 1'b0) bad_rw++;
      if (en_tr[i] && !en_tr[i-1]) rises++;
      if ((first_rdy < 0) && rdy_tr[i]) first_rdy = i;
    end
    check({tag, "_latency"}, first_rdy - t, r - t);
    check({tag, "_en_pulses"}, rises, 2);
    check({tag, "_en_bad_cycles"}, bad_en, 0);
    check({tag, "_data_bad_cycles"}, bad_d, 0);
    check({tag, "_rs_bad_cycles"}, bad_rs, 0);
    check({tag, "_ready_bad_cycles"}, bad_rdy, 0);
    check({tag, "_error_bad_cycles"}, bad_err, 0);
    check({tag, "_rw_bad_cycles"}, bad_rw, 0);
    $display("byte 0x%02h checked: start %0d ready %0d pulse %0d gap %0d", b, t, first_rdy, L, g);
  endtask

  initial begin
    int t, t0, t1, t2, rc, p, x0, cnt_en, cnt_d;
    logic [7:0] b0, b1, b2;
    logic rs1, rs2;

    Reset  = 1'b1;
    iValid = 1'b0;
    iData  = 8'h00;
    iRS    = 1'b0;
    tick(4);

    // Reset state.
    @(negedge Clock);
    check("rst_ready", oReady, 0);
    check("rst_lcd_d", oLCD_D, 0);
    check("rst_lcd_rs", oLCD_RS, 0);
    check("rst_lcd_rw", oLCD_RW, 0);
    check("rst_enstart", oEnStart, 0);
    check("rst_error", oError, 0);
    @(posedge Clock); #2;
    Reset = 1'b0;
    @(negedge Clock);
    check("ready_first_cycle_after_reset", oReady, 0);
    @(posedge Clock); #2;
    @(negedge Clock);
    check("ready_after_reset", oReady, 1);
    $display("reset sequence done at cycle %0d", cyc);

    // Spurious iEnDone while idle.
    @(posedge Clock); #2;
    spurious = 1'b1;
    tick(5);
    spurious = 1'b0;
    tick(2);
    @(negedge Clock);
    check("idle_spur_ready", oReady, 1);
    check("idle_spur_enstart", oEnStart, 0);
    check("idle_spur_error", oError, 0);
    @(posedge Clock); #2;

    // Data write 0x41, P = 16, with spurious iEnDone in both gaps.
    resp_p = 16;
    send(8'h41, 1'b1, 1'b0, t);
    wait_cycle(t + 2 + 16 + 5);
    spurious = 1'b1;
    tick(10);
    spurious = 1'b0;
    wait_cycle(t + 2 * 17 + NG + 20);
    spurious = 1'b1;
    tick(20);
    spurious = 1'b0;
    verify_byte("data41", t, 8'h41, 1'b1, 16, 1'b0, 1'b0);

    // Clear command with the enable generator silent: both pulses time out.
    resp_on = 1'b0;
    send(CLEAR_BYTE(), 1'b0, 1'b0, t);
    verify_byte("clear_timeout", t, 8'h01, 1'b0, TO, 1'b0, 1'b1);
    resp_on = 1'b1;

    // Reset during the nibble gap aborts the byte.
    p = $urandom_range(2, 20);
    resp_p = p;
    b0 = 8'(($urandom_range(1, 15) << 4) | $urandom_range(0, 15));
    send(b0, 1'b1, 1'b0, t);
    wait_cycle(t + 2 + p + 10);
    rc = cyc;
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
    tick(200);
    cnt_en = 0;
    for (int i = t + 1; i <= rc; i++) if (en_tr[i]) cnt_en++;
    check("abort_hi_pulse_len", cnt_en, p);
    check("abort_enstart", en_tr[rc+1], 0);
    check("abort_lcd_d", d_tr[rc+1], 0);
    check("abort_lcd_rs", rs_tr[rc+1], 0);
    check("abort_ready", rdy_tr[rc+1], 0);
    check("abort_error_cleared", err_tr[rc+1], 0);
    check("abort_ready_first_after", rdy_tr[rc+2], 0);
    check("abort_ready_back", rdy_tr[rc+3], 1);
    cnt_en = 0; cnt_d = 0;
    for (int i = rc + 1; i < rc + 200; i++) begin
      if (en_tr[i]) cnt_en++;
      if (d_tr[i] !== 4'h0) cnt_d++;
    end
    check("abort_no_low_nibble_pulses", cnt_en, 0);
    check("abort_data_stays_zero", cnt_d, 0);
    $display("reset abort of byte 0x%02h at cycle %0d checked", b0, rc);

    // iValid held with three bytes queued.
    p = $urandom_range(1, 24);
    resp_p = p;
    b1 = 8'($urandom_range(0, 255));
    rs1 = 1'($urandom_range(0, 1));
    if (!rs1 && (b1 >= 8'd1) && (b1 <= 8'd3)) b1 = b1 | 8'h10;
    b2 = 8'($urandom_range(0, 255));
    rs2 = 1'($urandom_range(0, 1));
    if (!rs2 && (b2 >= 8'd1) && (b2 <= 8'd3)) b2 = b2 | 8'h10;
    x0 = xfer_cnt;
    send(8'h28, 1'b0, 1'b1, t0);
    send(b1, rs1, 1'b1, t1);
    send(b2, rs2, 1'b0, t2);
    check("queue_second_at_first_idle", t1 - t0, 2 * (1 + p) + NG + BG + 1);
    check("queue_third_at_first_idle", t2 - t1, 2 * (1 + p) + NG + gap_of(b1, rs1) + 1);
    verify_byte("cmd28", t0, 8'h28, 1'b0, p, 1'b0, 1'b0);
    verify_byte("queued1", t1, b1, rs1, p, 1'b0, 1'b0);
    verify_byte("queued2", t2, b2, rs2, p, 1'b0, 1'b0);
    tick(10);
    check("queue_transfer_count", xfer_cnt - x0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  function automatic logic [7:0] CLEAR_BYTE();
    return 8'h01;
  endfunction

endmodule
